// File: rtl/keypad_entry.sv
// Keypad entry front end: synchronises and debounces the scanner's key-down flag,
// turns each accepted press into one key event and builds BCD numbers from digit keys.
module keypad_entry #(
  parameter int DEB_CYCLES = 16,
  parameter int NDIG       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        posicion,
  input  logic              opr,
  output logic [4*NDIG-1:0] digitos,
  output logic [3:0]        n_dig,
  output logic [4*NDIG-1:0] valor,
  output logic              valor_valid,
  output logic [1:0]        func_code,
  output logic              func_valid
);

  localparam int              W       = 4 * NDIG;
  localparam int              CW      = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEB_CYCLES);
  localparam logic [3:0]      NDIG_L  = 4'(NDIG);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;
  typedef enum logic [1:0] {K_DIGIT, K_CLEAR, K_ENTER, K_FUNC} kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [3:0] val;   // BCD digit, or function index for A..D
  } key_t;

  function automatic key_t decode(input logic [3:0] p);
    key_t k;
    k.kind = K_DIGIT;
    k.val  = 4'd0;
    case (p)
      4'd0:  k.val = 4'd1;
      4'd1:  k.val = 4'd2;
      4'd2:  k.val = 4'd3;
      4'd3:  begin k.kind = K_FUNC; k.val = 4'd0; end
      4'd4:  k.val = 4'd4;
      4'd5:  k.val = 4'd5;
      4'd6:  k.val = 4'd6;
      4'd7:  begin k.kind = K_FUNC; k.val = 4'd1; end
      4'd8:  k.val = 4'd7;
      4'd9:  k.val = 4'd8;
      4'd10: k.val = 4'd9;
      4'd11: begin k.kind = K_FUNC; k.val = 4'd2; end
      4'd12: k.kind = K_CLEAR;
      4'd13: k.val = 4'd0;
      4'd14: k.kind = K_ENTER;
      default: begin k.kind = K_FUNC; k.val = 4'd3; end
    endcase
    return k;
  endfunction

  // The position bus rides through the same two stages as the flag so both stay aligned.
  logic       opr_m, opr_s;
  logic [3:0] pos_m, pos_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opr_m <= 1'b0;
      opr_s <= 1'b0;
      pos_m <= 4'd0;
      pos_s <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments here are what make this a two-stage shift; blocking ones would collapse it to one flop.
      opr_m <= opr;
      opr_s <= opr_m;
      pos_m <= posicion;
      pos_s <= pos_m;
    end
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    pos_cap;
  key_t          key;

  assign key = decode(pos_cap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the entry buffer is a plain register, not a RAM, so it clears with everything else on reset.
      state       <= IDLE;
      cnt         <= '0;
      pos_cap     <= 4'd0;
      digitos     <= '0;
      n_dig       <= 4'd0;
      valor       <= '0;
      valor_valid <= 1'b0;
      func_code   <= 2'd0;
      func_valid  <= 1'b0;
    end else begin
      valor_valid <= 1'b0;
      func_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (opr_s) begin
            state   <= DEB_PRESS;
            cnt     <= CW'(1);
            pos_cap <= pos_s;
          end
        end
        DEB_PRESS: begin
          if (!opr_s) begin
            state <= IDLE;
          end else if (pos_s != pos_cap) begin
            pos_cap <= pos_s;
            cnt     <= CW'(1);
          end else if (cnt == CNT_MAX) begin
            state <= HELD;
            case (key.kind)
              K_DIGIT: begin
                // A full buffer silently drops further digits rather than wrapping.
                if (n_dig < NDIG_L) begin
                  digitos <= (digitos << 4) | W'(key.val);
                  n_dig   <= n_dig + 4'd1;
                end
              end
              K_CLEAR: begin
                digitos <= '0;
                n_dig   <= 4'd0;
              end
              K_ENTER: begin
                valor       <= digitos;
                valor_valid <= 1'b1;
                digitos     <= '0;
                n_dig       <= 4'd0;
              end
              K_FUNC: begin
                func_code  <= key.val[1:0];
                func_valid <= 1'b1;
              end
            endcase
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!opr_s) begin
            state <= DEB_REL;
            cnt   <= CW'(1);
          end
        end
        DEB_REL: begin
          if (opr_s) begin
            state <= HELD;
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: key-press table, hand-written debounce/reset sequences,
// and random presses compared every cycle against a run-length behavioural model.
module tb_keypad_entry;

  localparam int DEB  = 4;
  localparam int NDIG = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        opr = 1'b0;
  logic [3:0]  posicion = 4'd0;
  logic [15:0] digitos;
  logic [3:0]  n_dig;
  logic [15:0] valor;
  logic        valor_valid;
  logic [1:0]  func_code;
  logic        func_valid;

  keypad_entry #(.DEB_CYCLES(DEB), .NDIG(NDIG)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .posicion    (posicion),
    .opr         (opr),
    .digitos     (digitos),
    .n_dig       (n_dig),
    .valor       (valor),
    .valor_valid (valor_valid),
    .func_code   (func_code),
    .func_valid  (func_valid)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;
  int vp_cnt = 0;
  int fp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a press is accepted after DEB+1 consecutive synchronised samples
  // showing the same key down; a release after DEB+1 consecutive samples showing it up.
  typedef struct packed {logic o; logic [3:0] p;} samp_t;
  samp_t       hist[$];
  int          run_hi = 0, run_lo = 0;
  logic [3:0]  run_pos = 4'd0;
  bit          m_held = 1'b0;
  int          m_buf[$];
  logic [15:0] m_valor = 16'd0;
  logic [1:0]  m_fc = 2'd0;
  bit          m_vv = 1'b0, m_fv = 1'b0;

  function automatic logic [15:0] fold();
    logic [15:0] v = 16'd0;
    foreach (m_buf[i]) v = (v << 4) | 16'(m_buf[i]);
    return v;
  endfunction

  task automatic m_apply(input int p);
    int row = p / 4;
    int col = p % 4;
    if (col == 3) begin
      m_fc = 2'(row);
      m_fv = 1'b1;
    end else if (row == 3 && col == 0) begin
      m_buf.delete();
    end else if (row == 3 && col == 2) begin
      m_valor = fold();
      m_vv    = 1'b1;
      m_buf.delete();
    end else begin
      int d = (row == 3) ? 0 : row * 3 + col + 1;
      if (m_buf.size() < NDIG) m_buf.push_back(d);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
      run_hi = 0; run_lo = 0; run_pos = 4'd0; m_held = 1'b0;
      m_buf.delete();
      m_valor = 16'd0; m_fc = 2'd0; m_vv = 1'b0; m_fv = 1'b0;
    end else begin
      samp_t s;
      hist.push_back('{opr, posicion});
      s = hist.pop_front();
      m_vv = 1'b0;
      m_fv = 1'b0;
      if (!m_held) begin
        if (s.o) begin
          if (run_hi > 0 && s.p == run_pos) run_hi++;
          else begin run_hi = 1; run_pos = s.p; end
          if (run_hi == DEB + 1) begin
            m_apply(int'(run_pos));
            m_held = 1'b1;
            run_lo = 0;
          end
        end else begin
          run_hi = 0;
        end
      end else if (!s.o) begin
        run_lo++;
        if (run_lo == DEB + 1) begin m_held = 1'b0; run_hi = 0; end
      end else begin
        run_lo = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (valor_valid) vp_cnt++;
      if (func_valid) fp_cnt++;
      check("model", {digitos, n_dig, valor, valor_valid, func_code, func_valid},
                     {fold(), 4'(m_buf.size()), m_valor, m_vv, m_fc, m_fv});
    end
  endtask

  task automatic press(input logic [3:0] p, input int hi, input int lo);
    posicion = p;
    opr = 1'b1;
    tick(hi);
    opr = 1'b0;
    tick(lo);
  endtask

  typedef struct {
    logic [3:0]  pos;
    logic [15:0] dig;
    logic [3:0]  nd;
    logic [15:0] val;
    logic [1:0]  fc;
    int          vp;
    int          fp;
  } vec_t;
  vec_t tbl[18];

  initial begin
    tbl[0]  = '{4'd12, 16'h0000, 4'd0, 16'h0000, 2'd0, 0, 0};
    tbl[1]  = '{4'd0,  16'h0001, 4'd1, 16'h0000, 2'd0, 0, 0};
    tbl[2]  = '{4'd1,  16'h0012, 4'd2, 16'h0000, 2'd0, 0, 0};
    tbl[3]  = '{4'd2,  16'h0123, 4'd3, 16'h0000, 2'd0, 0, 0};
    tbl[4]  = '{4'd4,  16'h1234, 4'd4, 16'h0000, 2'd0, 0, 0};
    tbl[5]  = '{4'd5,  16'h1234, 4'd4, 16'h0000, 2'd0, 0, 0};
    tbl[6]  = '{4'd12, 16'h0000, 4'd0, 16'h0000, 2'd0, 0, 0};
    tbl[7]  = '{4'd10, 16'h0009, 4'd1, 16'h0000, 2'd0, 0, 0};
    tbl[8]  = '{4'd13, 16'h0090, 4'd2, 16'h0000, 2'd0, 0, 0};
    tbl[9]  = '{4'd14, 16'h0000, 4'd0, 16'h0090, 2'd0, 1, 0};
    tbl[10] = '{4'd14, 16'h0000, 4'd0, 16'h0000, 2'd0, 1, 0};
    tbl[11] = '{4'd3,  16'h0000, 4'd0, 16'h0000, 2'd0, 0, 1};
    tbl[12] = '{4'd11, 16'h0000, 4'd0, 16'h0000, 2'd2, 0, 1};
    tbl[13] = '{4'd6,  16'h0006, 4'd1, 16'h0000, 2'd2, 0, 0};
    tbl[14] = '{4'd7,  16'h0006, 4'd1, 16'h0000, 2'd1, 0, 1};
    tbl[15] = '{4'd15, 16'h0006, 4'd1, 16'h0000, 2'd3, 0, 1};
    tbl[16] = '{4'd9,  16'h0068, 4'd2, 16'h0000, 2'd3, 0, 0};
    tbl[17] = '{4'd14, 16'h0000, 4'd0, 16'h0068, 2'd3, 1, 0};

    // Reset state
    tick(3);
    check("reset", {digitos, n_dig, valor, valor_valid, func_code, func_valid}, 64'd0);
    rst_n = 1'b1;

    // First-press latency: action lands on edge DEB+2 and nothing repeats while held
    posicion = 4'd5;
    opr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("latency_dig", digitos, (i >= DEB + 2) ? 16'h0005 : 16'h0000);
      check("latency_n", n_dig, (i >= DEB + 2) ? 4'd1 : 4'd0);
    end
    opr = 1'b0;
    tick(10);

    // Key table
    for (int i = 0; i < 18; i++) begin
      vp_cnt = 0;
      fp_cnt = 0;
      press(tbl[i].pos, 10, 10);
      check($sformatf("tbl%0d_dig", i), digitos, tbl[i].dig);
      check($sformatf("tbl%0d_n", i), n_dig, tbl[i].nd);
      check($sformatf("tbl%0d_valor", i), valor, tbl[i].val);
      check($sformatf("tbl%0d_fc", i), func_code, tbl[i].fc);
      check($sformatf("tbl%0d_vpulses", i), vp_cnt, tbl[i].vp);
      check($sformatf("tbl%0d_fpulses", i), fp_cnt, tbl[i].fp);
    end

    // Short glitch is rejected, then a real A press
    press(4'd8, 10, 10);
    vp_cnt = 0;
    fp_cnt = 0;
    posicion = 4'd3;
    opr = 1'b1;
    tick(3);
    opr = 1'b0;
    tick(10);
    check("glitch_dig", digitos, 16'h0007);
    check("glitch_pulses", vp_cnt + fp_cnt, 0);
    press(4'd3, 10, 10);
    check("funcA_pulses", fp_cnt, 1);
    check("funcA_code", func_code, 2'd0);
    check("funcA_dig", digitos, 16'h0007);

    // Release bounce yields a single digit
    press(4'd12, 10, 10);
    posicion = 4'd8;
    opr = 1'b1; tick(10);
    opr = 1'b0; tick(2);
    opr = 1'b1; tick(2);
    opr = 1'b0; tick(10);
    check("bounce_dig", digitos, 16'h0007);
    check("bounce_n", n_dig, 4'd1);
    vp_cnt = 0;
    fp_cnt = 0;
    press(4'd12, 10, 10);
    check("star_dig", {digitos, n_dig}, 20'd0);
    check("star_pulses", vp_cnt + fp_cnt, 0);

    // Reset while held: async clear, then full debounce again
    posicion = 4'd1;
    opr = 1'b1;
    tick(10);
    check("held_dig", digitos, 16'h0002);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {digitos, n_dig, valor, valor_valid, func_code, func_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("rst_relatch_dig", digitos, (i >= DEB + 2) ? 16'h0002 : 16'h0000);
    end
    opr = 1'b0;
    tick(10);

    // Random presses with bounces and mid-press key changes
    for (int n = 0; n < 200; n++) begin
      posicion = 4'($urandom_range(0, 15));
      opr = 1'b1;
      tick($urandom_range(1, 14));
      if ($urandom_range(0, 3) == 0) begin
        posicion = 4'($urandom_range(0, 15));
        tick($urandom_range(1, 8));
      end
      opr = 1'b0;
      tick($urandom_range(1, 10));
      if ($urandom_range(0, 4) == 0) begin
        opr = 1'b1;
        tick($urandom_range(1, 3));
        opr = 1'b0;
        tick(8);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
